// File: rtl/ifetch_unit_if.sv
// ----------------------------------------------------------------------------
// ifetch_unit_if
//   Bundles the two handshakes owned by the fetch unit:
//     - instruction-memory read port (level request, one-cycle rvalid pulse)
//     - decode port (inst_valid / inst_ready)
//   master : the fetch unit (drives imem request and decoded-instruction side)
//   slave  : the environment (instruction memory + decode stage)
// Signals
//   imem_req    fetch -> mem   request outstanding (level)
//   imem_addr   fetch -> mem   request address, stable while imem_req=1
//   imem_rvalid mem -> fetch   one-cycle pulse, imem_rdata valid
//   imem_rdata  mem -> fetch   fetched instruction word
//   inst_valid  fetch -> dec   inst/inst_pc hold a fetched instruction
//   inst_ready  dec -> fetch   decode accepts inst this cycle
//   inst        fetch -> dec   instruction word (NOP when not valid)
//   inst_pc     fetch -> dec   address of inst
// ----------------------------------------------------------------------------
interface ifetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_rvalid, imem_rdata, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_rvalid, imem_rdata, inst_ready
    );
endinterface

// File: rtl/ifetch_unit.sv
// ----------------------------------------------------------------------------
// ifetch_unit
//   Instruction-fetch / next-PC unit. Holds the PC, keeps exactly one read
//   outstanding to instruction memory, hands fetched words to decode with a
//   valid/ready handshake and squashes wrong-path fetches when execute
//   resolves a taken branch or jump.
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (master)      imem read port + decode handshake (see ifetch_unit_if)
//   resolve_valid     execute-stage control-flow fields valid this cycle
//   Branch, Jump      conditional branch / jal-jalr being resolved
//   jalr              with Jump: target comes from ALUResult
//   zero, less        ALU branch-condition flags
//   ALUResult         jalr target
//   imm32, ex_pc      branch/jal offset and PC of the resolving instruction
//   pc                current fetch PC
//   redirect          one-cycle pulse after a taken resolve was sampled
//   misalign          pulses with redirect when the raw target is not word aligned
// ----------------------------------------------------------------------------
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst_n,
    ifetch_unit_if.master bus,
    input  logic         resolve_valid,
    input  logic         Branch,
    input  logic         Jump,
    input  logic         jalr,
    input  logic         zero,
    input  logic         less,
    input  logic [31:0]  ALUResult,
    input  logic [31:0]  imm32,
    input  logic [31:0]  ex_pc,
    output logic [31:0]  pc,
    output logic         redirect,
    output logic         misalign
);

    typedef enum logic [1:0] {
        S_FETCH, // idle: issue next request unless redirected
        S_WAIT,  // request outstanding, response wanted
        S_HOLD,  // instruction presented to decode
        S_DRAIN  // request outstanding, response will be discarded
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic        imem_req_q;
    logic [31:0] imem_addr_q;
    logic        inst_valid_q;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic        redirect_q;
    logic        misalign_q;

    logic        taken;
    logic [31:0] target;
    logic [31:0] target_aligned;

    // Jump wins over Branch simply because it alone makes the resolve taken.
    assign taken          = resolve_valid & (Jump | (Branch & (zero | less)));
    assign target         = (Jump & jalr) ? ALUResult : ex_pc + imm32;
    assign target_aligned = {target[31:2], 2'b00};

    // NOTE: all state lives in this one clocked block and is updated with
    // non-blocking assignments, so every branch reads pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            imem_req_q   <= 1'b0;
            imem_addr_q  <= RESET_PC;
            inst_valid_q <= 1'b0;
            inst_q       <= NOP_INST;
            inst_pc_q    <= 32'h0;
            redirect_q   <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            redirect_q <= taken;
            misalign_q <= taken & (|target[1:0]);

            unique case (state_q)
                S_FETCH: begin
                    if (taken) begin
                        pc_q <= target_aligned;
                    end else begin
                        state_q     <= S_WAIT;
                        imem_addr_q <= pc_q;
                        imem_req_q  <= 1'b1;
                    end
                end

                S_WAIT: begin
                    if (taken) begin
                        pc_q <= target_aligned;
                        if (bus.imem_rvalid) begin
                            // Response arrived with the redirect: drop it.
                            state_q    <= S_FETCH;
                            imem_req_q <= 1'b0;
                        end else begin
                            // Still owe the memory a response; swallow it later.
                            state_q <= S_DRAIN;
                        end
                    end else if (bus.imem_rvalid) begin
                        state_q      <= S_HOLD;
                        imem_req_q   <= 1'b0;
                        inst_q       <= bus.imem_rdata;
                        inst_pc_q    <= imem_addr_q;
                        inst_valid_q <= 1'b1;
                        pc_q         <= pc_q + 32'd4;
                    end
                end

                S_HOLD: begin
                    // A redirect squashes the held word even if decode is ready.
                    if (taken) begin
                        state_q      <= S_FETCH;
                        inst_valid_q <= 1'b0;
                        inst_q       <= NOP_INST;
                        pc_q         <= target_aligned;
                    end else if (bus.inst_ready) begin
                        state_q      <= S_WAIT;
                        inst_valid_q <= 1'b0;
                        inst_q       <= NOP_INST;
                        imem_addr_q  <= pc_q;
                        imem_req_q   <= 1'b1;
                    end
                end

                S_DRAIN: begin
                    if (taken) begin
                        pc_q <= target_aligned;
                    end
                    if (bus.imem_rvalid) begin
                        state_q    <= S_FETCH;
                        imem_req_q <= 1'b0;
                    end
                end

                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign bus.imem_req   = imem_req_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign pc             = pc_q;
    assign redirect       = redirect_q;
    assign misalign       = misalign_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// ----------------------------------------------------------------------------
// tb_ifetch_unit
//   Scoreboard bench for ifetch_unit. A memory model answers requests with a
//   random or fixed latency; the stimulus pushes expected redirects; a monitor
//   follows the program-order PC stream and checks every accepted instruction,
//   every redirect pulse and the HOLD-state invariants.
// ----------------------------------------------------------------------------
module tb_ifetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct {
        logic [31:0] target;
        logic        mis;
    } redir_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        resolve_valid, Branch, Jump, jalr, zero, less;
    logic [31:0] ALUResult, imm32, ex_pc;
    logic [31:0] pc;
    logic        redirect, misalign;

    ifetch_unit_if bus ();

    ifetch_unit #(
        .RESET_PC(RESET_PC),
        .NOP_INST(NOP_INST)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .resolve_valid(resolve_valid),
        .Branch       (Branch),
        .Jump         (Jump),
        .jalr         (jalr),
        .zero         (zero),
        .less         (less),
        .ALUResult    (ALUResult),
        .imm32        (imm32),
        .ex_pc        (ex_pc),
        .pc           (pc),
        .redirect     (redirect),
        .misalign     (misalign)
    );

    always #5 clk = ~clk;

    int     n_checks  = 0;
    int     n_fail    = 0;
    int     n_accept  = 0;
    int     fixed_lat = -1;
    bit     mem_en    = 1'b0;
    redir_t redir_q[$];

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference rule for a resolve: taken test, target, word alignment.
    task automatic push_expect();
        logic [31:0] t;
        redir_t      r;
        if (resolve_valid && (Jump || (Branch && (zero || less)))) begin
            t        = (Jump && jalr) ? ALUResult : ex_pc + imm32;
            r.target = t - (t % 4);
            r.mis    = (t % 4) != 0;
            redir_q.push_back(r);
        end
    endtask

    task automatic resolve(input bit b, input bit j, input bit jr, input bit z, input bit l,
                           input logic [31:0] alu, input logic [31:0] imm, input logic [31:0] epc);
        Branch = b; Jump = j; jalr = jr; zero = z; less = l;
        ALUResult = alu; imm32 = imm; ex_pc = epc;
        resolve_valid = 1'b1;
        push_expect();
        tick();
        resolve_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.inst_valid && k < 40);
        check(name, 32'(bus.inst_valid), 32'd1);
    endtask

    task automatic wait_accepts(input string name, input int n);
        int k;
        k = 0;
        while (n_accept < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(n_accept >= n), 32'd1);
    endtask

    // Returns at the negedge of the first cycle of a new request.
    task automatic wait_req_rise(input string name);
        logic prev;
        int   k;
        @(negedge clk);
        prev = bus.imem_req;
        k    = 0;
        do begin
            @(negedge clk);
            if (bus.imem_req && !prev) break;
            prev = bus.imem_req;
            k++;
        end while (k < 40);
        check(name, 32'(bus.imem_req), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_imem_req"},   32'(bus.imem_req),   32'd0);
        check({tag, "_imem_addr"},  bus.imem_addr,       RESET_PC);
        check({tag, "_inst_valid"}, 32'(bus.inst_valid), 32'd0);
        check({tag, "_inst"},       bus.inst,            NOP_INST);
        check({tag, "_inst_pc"},    bus.inst_pc,         32'd0);
        check({tag, "_pc"},         pc,                  RESET_PC);
        check({tag, "_redirect"},   32'(redirect),       32'd0);
        check({tag, "_misalign"},   32'(misalign),       32'd0);
    endtask

    // ---------------- instruction memory model ----------------
    initial begin : memory
        bit          busy;
        int          lat;
        logic [31:0] addr_l;
        busy = 1'b0;
        lat  = 0;
        addr_l = '0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            tick();
            if (!mem_en || !rst_n) begin
                busy = 1'b0;
                continue;
            end
            if (bus.imem_rvalid) begin
                bus.imem_rvalid = 1'b0;
                bus.imem_rdata  = $urandom;
                busy            = 1'b0;
                check("req_drop_after_rvalid", 32'(bus.imem_req), 32'd0);
            end else begin
                if (!busy && bus.imem_req) begin
                    busy   = 1'b1;
                    addr_l = bus.imem_addr;
                    lat    = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 3);
                end else if (busy) begin
                    check("req_held", 32'(bus.imem_req), 32'd1);
                    check("addr_stable", bus.imem_addr, addr_l);
                    if (lat > 0) lat--;
                end
                if (busy && lat == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = mem_word(addr_l);
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [31:0] exp_pc;
        logic [31:0] prev_inst, prev_ipc;
        bit          prev_hold;
        bit          tk;
        redir_t      r;
        exp_pc    = RESET_PC;
        prev_hold = 1'b0;
        prev_inst = '0;
        prev_ipc  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_pc    = RESET_PC;
                prev_hold = 1'b0;
                continue;
            end
            tk = resolve_valid && (Jump || (Branch && (zero || less)));

            if (redirect) begin
                check("redirect_expected", 32'(redir_q.size() != 0), 32'd1);
                if (redir_q.size() != 0) begin
                    r = redir_q.pop_front();
                    check("redirect_pc", pc, r.target);
                    check("redirect_misalign", 32'(misalign), 32'(r.mis));
                    exp_pc = r.target;
                end
            end else begin
                check("misalign_without_redirect", 32'(misalign), 32'd0);
            end

            if (prev_hold) begin
                check("hold_valid", 32'(bus.inst_valid), 32'd1);
                check("hold_inst", bus.inst, prev_inst);
                check("hold_inst_pc", bus.inst_pc, prev_ipc);
            end

            if (bus.inst_valid) begin
                check("valid_req_low", 32'(bus.imem_req), 32'd0);
                check("valid_pc_next", pc, bus.inst_pc + 32'd4);
            end else begin
                check("nop_when_invalid", bus.inst, NOP_INST);
            end

            if (bus.inst_valid && bus.inst_ready && !tk) begin
                check("inst_pc", bus.inst_pc, exp_pc);
                check("inst_word", bus.inst, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_accept++;
            end

            prev_hold = bus.inst_valid && !bus.inst_ready && !tk;
            prev_inst = bus.inst;
            prev_ipc  = bus.inst_pc;
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        logic [31:0] held_pc;
        int          a;

        rst_n = 1'b0;
        resolve_valid = 1'b0; Branch = 1'b0; Jump = 1'b0; jalr = 1'b0;
        zero = 1'b0; less = 1'b0;
        ALUResult = '0; imm32 = '0; ex_pc = '0;
        bus.inst_ready = 1'b0;
        repeat (2) tick();
        check_reset_values("reset");
        @(negedge clk);
        rst_n  = 1'b1;
        mem_en = 1'b1;

        // Sequential fetch from RESET_PC with decode always ready.
        tick();
        bus.inst_ready = 1'b1;
        repeat (30) tick();
        check("basic_progress", 32'(n_accept >= 3), 32'd1);

        // Decode stall: held instruction must stay put, no new request.
        bus.inst_ready = 1'b0;
        wait_valid("stall_wait_valid");
        held_pc = bus.inst_pc;
        repeat (5) @(negedge clk);
        check("stall_req_low", 32'(bus.imem_req), 32'd0);
        check("stall_pc", pc, held_pc + 32'd4);
        check("stall_inst_pc", bus.inst_pc, held_pc);
        tick();
        bus.inst_ready = 1'b1;
        a = n_accept;
        wait_accepts("stall_release", a + 2);

        // beq taken while a slow response is pending: DRAIN then 0x60.
        fixed_lat = 3;
        wait_req_rise("beq_req");
        tick();
        resolve(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h40, 32'h20);
        check("beq_redirect_pulse", 32'(redirect), 32'd1);
        check("beq_pc", pc, 32'h60);
        tick();
        check("beq_redirect_one_cycle", 32'(redirect), 32'd0);
        fixed_lat = -1;
        a = n_accept;
        wait_accepts("beq_next", a + 1);

        // jalr to a misaligned target while an instruction is held.
        bus.inst_ready = 1'b0;
        wait_valid("jalr_wait_valid");
        @(posedge clk);
        #1;
        bus.inst_ready = 1'b1;
        resolve(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1002, 32'h0, 32'h0);
        check("jalr_inst_valid_drop", 32'(bus.inst_valid), 32'd0);
        check("jalr_misalign", 32'(misalign), 32'd1);
        check("jalr_pc", pc, 32'h1000);
        a = n_accept;
        wait_accepts("jalr_next", a + 1);

        // jal near the top of memory: fetch wraps to address 0.
        resolve(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFF8, 32'h0);
        a = n_accept;
        wait_accepts("wrap_fetches", a + 3);
        // Branch with both flags clear is not taken.
        resolve(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h40, 32'h0);
        check("bnt_no_redirect", 32'(redirect), 32'd0);

        // Random traffic: decode back-pressure, latency and resolves.
        for (int i = 0; i < 1500; i++) begin
            bus.inst_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 11) == 0) begin
                Branch    = $urandom_range(0, 1) == 1;
                Jump      = $urandom_range(0, 3) == 0;
                jalr      = $urandom_range(0, 1) == 1;
                zero      = $urandom_range(0, 1) == 1;
                less      = $urandom_range(0, 1) == 1;
                ALUResult = $urandom_range(0, 65535) & 32'hFFFF_FFFE;
                ex_pc     = $urandom_range(0, 4095) * 4;
                imm32     = $urandom_range(0, 1023) * 4 - 2048;
                if ($urandom_range(0, 5) == 0) imm32 = imm32 + 32'd2;
                resolve_valid = 1'b1;
                push_expect();
            end else begin
                resolve_valid = 1'b0;
            end
            tick();
        end
        resolve_valid  = 1'b0;
        bus.inst_ready = 1'b1;
        repeat (10) tick();
        check("redirect_queue_empty", 32'(redir_q.size()), 32'd0);
        check("random_progress", 32'(n_accept > 100), 32'd1);

        // Reset in the middle of WAIT with stray responses around it.
        fixed_lat = 3;
        wait_req_rise("rst_req");
        mem_en = 1'b0;
        rst_n  = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        tick();
        check_reset_values("rst_mid");
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        check("rst_stray_ignored_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_restart_req", 32'(bus.imem_req), 32'd1);
        check("rst_restart_addr", bus.imem_addr, RESET_PC);
        fixed_lat = -1;
        mem_en = 1'b1;
        a = n_accept;
        wait_accepts("rst_refetch", a + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
